// File: rtl/mult_share_arbiter.sv
// Round-robin sequencer that shares one multi-cycle multiplier among N requesters.
// Each grant latches the winner's operands, pulses mul_start, and waits for done or a watchdog timeout.
module mult_share_arbiter #(
    parameter int N   = 4,
    parameter int W   = 8,
    parameter int TMO = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N*W-1:0]       a_in,
    input  logic [N*W-1:0]       b_in,
    output logic [N-1:0]         ack,
    output logic                 err,
    output logic [2*W-1:0]       result,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 busy,
    output logic                 mul_start,
    output logic [W-1:0]         mul_a,
    output logic [W-1:0]         mul_b,
    input  logic                 mul_done,
    input  logic [2*W-1:0]       mul_result
);

    localparam int IW  = $clog2(N);
    localparam int WDW = $clog2(TMO);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        ACK
    } state_t;

    state_t         state;
    logic [IW-1:0]  ptr;
    logic [IW-1:0]  winner;
    logic           found;
    logic [WDW-1:0] wd;
    int             idx;

    // Scan starts just after the last served requester, so the previous winner has lowest priority.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                winner = IW'(idx);
                found  = 1'b1;
            end
        end
    end

    assign busy = (state != IDLE);

    // ack, err and mul_start are pulses set on entry to their state and cleared on every other cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= IW'(N - 1);
            ack       <= '0;
            err       <= 1'b0;
            result    <= '0;
            grant_id  <= '0;
            mul_start <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            wd        <= '0;
        end else begin
            ack       <= '0;
            err       <= 1'b0;
            mul_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        grant_id  <= winner;
                        mul_a     <= a_in[int'(winner)*W +: W];
                        mul_b     <= b_in[int'(winner)*W +: W];
                        mul_start <= 1'b1;
                        state     <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    wd    <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // A done arriving on the last watchdog cycle still wins over the timeout.
                    if (mul_done) begin
                        result <= mul_result;
                        err    <= 1'b0;
                        ack    <= N'(1) << grant_id;
                        state  <= ACK;
                    end else if (wd == WDW'(TMO - 1)) begin
                        result <= '0;
                        err    <= 1'b1;
                        ack    <= N'(1) << grant_id;
                        state  <= ACK;
                    end else begin
                        wd <= wd + WDW'(1);
                    end
                end
                ACK: begin
                    ptr   <= grant_id;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Scoreboard bench for mult_share_arbiter: randomized requesters and a behavioural multiplier,
// with expected grants predicted from the round-robin rule and checked by an ack monitor.
module tb_mult_share_arbiter;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int TMO = 64;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N-1:0]         req;
    logic [N*W-1:0]       a_in;
    logic [N*W-1:0]       b_in;
    logic [N-1:0]         ack;
    logic                 err;
    logic [2*W-1:0]       result;
    logic [$clog2(N)-1:0] grant_id;
    logic                 busy;
    logic                 mul_start;
    logic [W-1:0]         mul_a;
    logic [W-1:0]         mul_b;
    logic                 mul_done;
    logic [2*W-1:0]       mul_result;

    mult_share_arbiter #(.N(N), .W(W), .TMO(TMO)) dut (
        .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
        .ack(ack), .err(err), .result(result), .grant_id(grant_id), .busy(busy),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_done(mul_done), .mul_result(mul_result)
    );

    always #5 clk = ~clk;

    typedef struct {
        int             id;
        logic [2*W-1:0] res;
        logic           err;
    } exp_t;

    exp_t           exp_q[$];
    exp_t           mon_e;
    int             checks = 0;
    int             errors = 0;
    int             cyc = 0;
    int             start_cyc = -1;
    int             mptr = N - 1;
    int             last_w = -1;
    logic [N-1:0]   pend;
    logic [W-1:0]   op_a[N];
    logic [W-1:0]   op_b[N];
    bit             mul_hang;
    int             mul_lat;
    int             mul_cnt = -1;
    logic [2*W-1:0] mul_prod;
    bit             stray_req;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Round-robin rule: first pending requester after the last served one, wrapping mod N.
    function automatic int rr_pick(input logic [N-1:0] p, input int ptr);
        for (int k = 1; k <= N; k++)
            if (p[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural multiplier: product after mul_lat cycles, never when hung, plus injected strays.
    initial begin
        mul_done   = 1'b0;
        mul_result = '0;
        forever begin
            @(posedge clk);
            #2;
            mul_done = 1'b0;
            if (mul_cnt > 0) begin
                mul_cnt--;
                if (mul_cnt == 0) begin
                    mul_done   = 1'b1;
                    mul_result = mul_prod;
                    mul_cnt    = -1;
                end
            end
            if (mul_start && !mul_hang) begin
                mul_cnt  = mul_lat;
                mul_prod = 16'(mul_a) * 16'(mul_b);
            end
            if (stray_req) begin
                mul_done   = 1'b1;
                mul_result = 16'h1234;
                stray_req  = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && ack != '0) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected_ack", 32'(ack), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_output("ack_vector", 32'(ack), 32'(1) << mon_e.id);
                check_output("result", 32'(result), 32'(mon_e.res));
                check_output("err", 32'(err), 32'(mon_e.err));
                check_output("grant_id", 32'(grant_id), 32'(mon_e.id));
            end
        end
        if (mul_start) start_cyc <= cyc;
    end

    task automatic drive_req();
        req = pend;
        for (int i = 0; i < N; i++) begin
            a_in[i*W +: W] = op_a[i];
            b_in[i*W +: W] = op_b[i];
        end
    endtask

    task automatic new_ops(input int i);
        op_a[i] = W'($urandom);
        op_b[i] = W'($urandom);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        pend      = '0;
        stray_req = 1'b0;
        drive_req();
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check_output("rst_ack", 32'(ack), 32'd0);
        check_output("rst_err", 32'(err), 32'd0);
        check_output("rst_result", 32'(result), 32'd0);
        check_output("rst_grant_id", 32'(grant_id), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_mul_start", 32'(mul_start), 32'd0);
        check_output("rst_mul_ab", {16'd0, mul_a, mul_b}, 32'd0);
        rst    = 1'b0;
        mptr   = N - 1;
        last_w = -1;
        exp_q.delete();
    endtask

    // Must be called at #1 into an IDLE cycle; returns at #1 into the IDLE cycle after ack.
    task automatic apply_stimulus(input bit hang, input int lat, input bit stray);
        int   w;
        int   t0;
        int   t_ack;
        bit   ok;
        exp_t e;
        drive_req();
        mul_hang = hang;
        mul_lat  = lat;
        t0       = cyc;
        t_ack    = 0;
        w        = rr_pick(pend, mptr);
        e.id     = w;
        e.err    = hang;
        e.res    = hang ? '0 : 16'(op_a[w]) * 16'(op_b[w]);
        exp_q.push_back(e);
        mptr   = w;
        last_w = w;
        if (stray) begin
            stray_req = 1'b1;
            @(posedge clk);
            #1;
            stray_req = 1'b1;
        end
        ok = 1'b0;
        for (int i = 0; i < TMO + lat + 10 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (ack != '0) begin
                ok    = 1'b1;
                t_ack = cyc;
            end
        end
        if (!ok) begin
            check_output("ack_timeout", 32'd0, 32'd1);
        end else begin
            check_output("start_latency", 32'(start_cyc), 32'(t0 + 1));
            check_output("ack_latency", 32'(t_ack), 32'(start_cyc + (hang ? TMO + 1 : lat + 1)));
        end
        @(posedge clk);
        #1;
        check_output("busy_after_ack", 32'(busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        bit seen;
        bit bad;
        rst       = 1'b1;
        pend      = '0;
        stray_req = 1'b0;
        mul_hang  = 1'b0;
        mul_lat   = 1;
        for (int i = 0; i < N; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end
        drive_req();
        do_reset();

        $display("[TB] single request, 12*10");
        pend = 4'b0001;
        op_a[0] = 8'd12;
        op_b[0] = 8'd10;
        apply_stimulus(1'b0, 3, 1'b0);

        $display("[TB] all four requesters held");
        do_reset();
        pend = 4'b1111;
        for (int i = 0; i < N; i++) begin
            op_a[i] = W'(8'd20 + 8'(i));
            op_b[i] = W'(8'd3 + 8'(i));
        end
        for (int t = 0; t < 7; t++) apply_stimulus(1'b0, 1 + (t % 3), 1'b0);

        $display("[TB] requesters 0 and 2 after serving 2");
        pend = 4'b0101;
        for (int t = 0; t < 3; t++) apply_stimulus(1'b0, 2, 1'b0);

        $display("[TB] watchdog timeout then normal");
        pend = 4'b0010;
        new_ops(1);
        apply_stimulus(1'b1, 1, 1'b0);
        new_ops(1);
        apply_stimulus(1'b0, 4, 1'b0);

        $display("[TB] reset during WAIT with late done");
        pend = 4'b0100;
        new_ops(2);
        drive_req();
        mul_hang = 1'b0;
        mul_lat  = 10;
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = mul_start;
        end
        check_output("abort_start_seen", 32'(seen), 32'd1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        do_reset();
        bad = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk);
            #1;
            bad |= busy | (|ack);
        end
        check_output("idle_after_abort", 32'(bad), 32'd0);
        pend = 4'b0101;
        new_ops(0);
        new_ops(2);
        apply_stimulus(1'b0, 2, 1'b0);

        $display("[TB] stray done in IDLE and LAUNCH, 0xFF*0xFF");
        pend = 4'b1000;
        op_a[3] = 8'hFF;
        op_b[3] = 8'hFF;
        apply_stimulus(1'b0, 2, 1'b1);

        $display("[TB] randomized traffic");
        for (int t = 0; t < 25; t++) begin
            if (last_w >= 0) begin
                if ($urandom_range(1, 0) == 0) pend[last_w] = 1'b0;
                else new_ops(last_w);
            end
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(2, 0) == 0) begin
                    pend[i] = 1'b1;
                    new_ops(i);
                end
            end
            if (pend == '0) begin
                int i;
                i = int'($urandom_range(N - 1, 0));
                pend[i] = 1'b1;
                new_ops(i);
            end
            apply_stimulus($urandom_range(9, 0) == 0,
                           ($urandom_range(9, 0) == 0) ? TMO : int'($urandom_range(6, 1)), 1'b0);
        end

        pend = '0;
        drive_req();
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        check_output("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
